// File: rtl/booth_mult_controller.sv
// booth_mult_controller: sequencer for an N-bit shift-add / radix-2 Booth multiplier datapath
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start, signed_mode  : multiply request (accepted in IDLE) and mode latched with it
//   abort               : synchronous cancel while busy
//   q0                  : current multiplier LSB from the datapath
//   ready, busy, done   : handshake status; done pulses once per completed product
//   ld_a, ld_b, clr_p   : operand load and partial-product clear
//   add_en, sub_en      : P <= P + A / P <= P - A
//   shift_en, shift_arith : shift {P,B} right, arithmetic when signed
//   iter                : remaining iterations
module booth_mult_controller #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic             q0,
    output logic             ready,
    output logic             busy,
    output logic             ld_a,
    output logic             ld_b,
    output logic             clr_p,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift_en,
    output logic             shift_arith,
    output logic             done,
    output logic [CNT_W-1:0] iter
);
    typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             q_m1, q_m1_d, mode_q, mode_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            q_m1   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            q_m1   <= q_m1_d;
            mode_q <= mode_d;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        q_m1_d  = q_m1;
        mode_d  = mode_q;
        case (state)
            IDLE: begin
                state_d = start ? LOAD : IDLE;
                mode_d  = start ? signed_mode : mode_q;
            end
            LOAD: begin
                state_d = EVAL;
                cnt_d   = CNT_W'(WIDTH);
                q_m1_d  = 1'b0;
            end
            EVAL: state_d = SHIFT;
            SHIFT: begin
                state_d = (cnt == CNT_W'(1)) ? DONE : EVAL;
                cnt_d   = cnt - 1'b1;
                q_m1_d  = q0;
            end
            default: state_d = IDLE;
        endcase
        if (abort && busy) begin
            state_d = IDLE;
            cnt_d   = '0;
            q_m1_d  = 1'b0;
        end
    end
    assign ready       = state == IDLE;
    assign busy        = state == LOAD || state == EVAL || state == SHIFT;
    assign ld_a        = state == LOAD;
    assign ld_b        = state == LOAD;
    assign clr_p       = state == LOAD;
    assign shift_en    = state == SHIFT;
    assign done        = state == DONE;
    assign shift_arith = mode_q;
    assign iter        = cnt;
    // Booth pairs {q0,q_m1}: 10 subtracts, 01 adds; unsigned mode adds on q0
    assign add_en = state == EVAL && (mode_q ? (!q0 && q_m1) : q0);
    assign sub_en = state == EVAL && mode_q && q0 && !q_m1;
endmodule

// File: tb/tb_booth_mult_controller.sv
// tb_booth_mult_controller: table-driven scoreboard bench for booth_mult_controller at WIDTH 4 and 8
module tb_booth_mult_controller;
    typedef struct packed {
        logic        w8;
        logic [7:0]  mult;
        logic        mode;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start4 = 1'b0, start8 = 1'b0, signed_mode = 1'b0, abort = 1'b0;
    logic sel8 = 1'b0;
    logic [7:0] mult_v = '0;
    logic [3:0] b4 = '0;
    logic [7:0] b8 = '0;
    logic ready4, busy4, ld_a4, ld_b4, clr_p4, add_en4, sub_en4, shift_en4, shift_arith4, done4;
    logic ready8, busy8, ld_a8, ld_b8, clr_p8, add_en8, sub_en8, shift_en8, shift_arith8, done8;
    logic [2:0] iter4;
    logic [3:0] iter8;
    logic ready, busy, ld_a, ld_b, clr_p, add_en, sub_en, shift_en, shift_arith, done;
    logic [3:0] iter;
    int checks = 0, errors = 0;
    logic [1:0] expq[$];

    always #5 clk = ~clk;

    booth_mult_controller #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode), .abort(abort), .q0(b4[0]),
        .ready(ready4), .busy(busy4), .ld_a(ld_a4), .ld_b(ld_b4), .clr_p(clr_p4), .add_en(add_en4),
        .sub_en(sub_en4), .shift_en(shift_en4), .shift_arith(shift_arith4), .done(done4), .iter(iter4)
    );
    booth_mult_controller #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(signed_mode), .abort(abort), .q0(b8[0]),
        .ready(ready8), .busy(busy8), .ld_a(ld_a8), .ld_b(ld_b8), .clr_p(clr_p8), .add_en(add_en8),
        .sub_en(sub_en8), .shift_en(shift_en8), .shift_arith(shift_arith8), .done(done8), .iter(iter8)
    );

    // multiplier shift register of the datapath, feeding q0
    always_ff @(posedge clk) begin
        b4 <= ld_b4 ? mult_v[3:0] : shift_en4 ? {1'b0, b4[3:1]} : b4;
        b8 <= ld_b8 ? mult_v : shift_en8 ? {1'b0, b8[7:1]} : b8;
    end

    assign {ready, busy, ld_a, ld_b, clr_p, add_en, sub_en, shift_en, shift_arith, done} = sel8 ?
        {ready8, busy8, ld_a8, ld_b8, clr_p8, add_en8, sub_en8, shift_en8, shift_arith8, done8} :
        {ready4, busy4, ld_a4, ld_b4, clr_p4, add_en4, sub_en4, shift_en4, shift_arith4, done4};
    assign iter = sel8 ? iter8 : {1'b0, iter4};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // start accepted at edge 0; loop index c is the cycle number of the period being observed
    task automatic run(input vec_t r, input int abort_c, input int bstart_c, input int flip_c);
        int w, shifts, dones;
        logic [1:0] e;
        bit aborted;
        w = r.w8 ? 8 : 4;
        sel8 = r.w8;
        mult_v = r.mult;
        signed_mode = r.mode;
        for (int i = 0; i < w; i++) expq.push_back(r.exp[2*i +: 2]);
        if (r.w8) start8 = 1'b1; else start4 = 1'b1;
        tick();
        shifts = 0;
        dones = 0;
        aborted = 1'b0;
        for (int c = 1; c <= 2*w + 3; c++) begin
            if (r.w8) start8 = (c == bstart_c); else start4 = (c == bstart_c);
            abort = (c == abort_c);
            if (c == flip_c) signed_mode = ~signed_mode;
            if (aborted) begin
                if (c == abort_c + 1) begin
                    check("abort_ready", ready, 1'b1);
                    check("abort_iter", iter, 0);
                end
            end else begin
                if (c == 1) check("load", {busy, ld_a, ld_b, clr_p}, 4'b1111);
                if (c >= 2 && c <= 2*w + 1) check("iter", iter, w - (c - 2) / 2);
                if (c >= 2 && c <= 2*w && c % 2 == 0) begin
                    e = expq.pop_front();
                    check("eval_strobes", {add_en, sub_en}, e);
                end
                if (c >= 3 && c <= 2*w + 1 && c % 2 == 1) begin
                    check("shift_en", shift_en, 1'b1);
                    check("shift_arith", shift_arith, r.mode);
                end
                if (c == 2*w + 2) check("done", {done, iter}, {1'b1, 4'd0});
                if (c == 2*w + 3) check("ready_after", {ready, busy}, 2'b10);
            end
            shifts += int'(shift_en);
            dones += int'(done);
            if (c == abort_c) aborted = 1'b1;
            tick();
        end
        start4 = 1'b0;
        start8 = 1'b0;
        abort = 1'b0;
        expq.delete();
        check("done_count", dones, abort_c != 0 ? 0 : 1);
        if (abort_c == 0) check("shift_count", shifts, w);
    endtask

    initial begin
        vec_t tbl[9];
        tbl[0] = '{1'b0, 8'h0D, 1'b0, 16'h00A2};
        tbl[1] = '{1'b0, 8'h0D, 1'b1, 16'h0019};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 16'h0000};
        tbl[3] = '{1'b0, 8'h0F, 1'b0, 16'h00AA};
        tbl[4] = '{1'b0, 8'h0F, 1'b1, 16'h0001};
        tbl[5] = '{1'b0, 8'h06, 1'b1, 16'h0084};
        tbl[6] = '{1'b0, 8'h0A, 1'b0, 16'h0088};
        tbl[7] = '{1'b1, 8'h80, 1'b1, 16'h4000};
        tbl[8] = '{1'b1, 8'hFF, 1'b0, 16'hAAAA};
        start4 = 1'b1;
        #1;
        check("rst_outs", {ready4, busy4, ld_a4, ld_b4, clr_p4, add_en4, sub_en4, shift_en4, shift_arith4, done4}, 10'b1000000000);
        check("rst_iter", iter4, 0);
        tick();
        tick();
        check("rst_hold", {ready4, busy4, ld_a4, done4, iter4}, {4'b1000, 3'd0});
        rst_n = 1'b1;
        tick();
        check("post_rst_load", {ld_a4, busy4, ready4}, 3'b110);
        start4 = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("post_rst_idle", ready4, 1'b1);
        for (int i = 0; i < 9; i++) run(tbl[i], 0, 0, 0);
        run(tbl[0], 5, 0, 0);
        run(tbl[1], 0, 4, 0);
        run(tbl[1], 0, 0, 3);
        run(tbl[0], 0, 0, 5);
        // asynchronous reset while in EVAL after one shift of 1101 (q_m1 was 1)
        sel8 = 1'b0;
        mult_v = 8'h0D;
        signed_mode = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst", {ready4, busy4, done4, iter4, u4.q_m1}, {3'b100, 3'd0, 1'b0});
        tick();
        rst_n = 1'b1;
        tick();
        run(tbl[5], 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
